neuron_scheduler: RTL and testbench
===================================

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 SHALL have parameters: NUM_NEURONS, default 8, neurons time-shared on one potential adder; DECAY_SHIFT, default 3, leak shift; TIMEOUT, default 15, max WAIT cycles.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins one sweep over all neurons.
- model_sel  in  2  model code driven to the adder (`LIF or `QLIF).
- w_wr  in  1  write strobe, per-neuron accumulated input weight.
- w_addr  in  3  neuron index for w_wr.
- w_data  in  32  weight value.
- vt_wr  in  1  write strobe, per-neuron threshold.
- vt_addr  in  3  neuron index for vt_wr.
- vt_data  in  32  threshold value.
- pot_rd_addr  in  3  potential read index.
- pot_rd_data  out  32  combinational potential[pot_rd_addr].
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- timeout_err  out  1  sticky; set on any adder timeout; cleared by start.
- spike_vec  out  NUM_NEURONS  per-neuron spike from latest evaluation.
- adder_time_step  out  1  adder time_step.
- adder_input_weight  out  32  adder input_weight.
- adder_decayed_potential  out  32  adder decayed_potential.
- adder_model  out  2  adder model.
- adder_init_mode  out  3  adder init_mode.
- adder_load  out  1  adder load; held 0.
- adder_final_potential  in  32  adder result.
- adder_spike  in  1  adder spike.
- adder_done  in  1  adder done.

Function
REQ-003 SHALL hold internal tables weight[N], vt[N], potential[N], all 32-bit unsigned.
REQ-004 SHALL implement states IDLE, CFG, SETTLE, FIRE, WAIT, WB, GAP, FIN.
REQ-005 IDLE: start=1 -> CFG with idx=0, timeout_err cleared; start while not IDLE SHALL be ignored.
REQ-006 CFG (1 cycle): adder_init_mode=`VT, adder_input_weight=vt[idx]; -> SETTLE.
REQ-007 SETTLE (1 cycle): adder_init_mode=`DEFAULT; -> FIRE.
REQ-008 FIRE (1 cycle): adder_time_step=1, adder_input_weight=weight[idx], adder_decayed_potential=potential[idx]-(potential[idx]>>DECAY_SHIFT); adder_done SHALL be ignored in FIRE (may be stale); -> WAIT.
REQ-009 WAIT: time_step, weight, decayed potential held; adder_done=1 -> WB; wait counter reaching TIMEOUT with no done -> set timeout_err, -> GAP, idx's tables and spike bit unchanged.
REQ-010 WB (1 cycle): potential[idx]<=adder_final_potential, spike_vec[idx]<=adder_spike, weight[idx]<=0; -> GAP.
REQ-011 GAP (1 cycle): adder_time_step=0; idx==NUM_NEURONS-1 -> FIN, else idx+1 -> CFG.
REQ-012 FIN (1 cycle): sweep_done=1; -> IDLE.
REQ-013 adder_init_mode SHALL be `DEFAULT in all states except CFG; adder_time_step SHALL be 1 only in FIRE, WAIT and WB; adder_model=model_sel captured at start, held for the sweep.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Host writes SHALL be accepted in any state; w_wr to idx in the WB cycle SHALL win over the clear; vt_wr to idx after CFG takes effect next sweep.
REQ-016 Decay subtraction SHALL not underflow (shift-subtract of unsigned value); all sums wrap modulo 2^32.
REQ-017 Latency per neuron with LIF adder = 4 + adder done latency + 1 cycles; sweep_done at fixed cycle count for fixed adder latency.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, idx=0, all tables to 0, spike_vec=0, busy=0, sweep_done=0, timeout_err=0, adder_time_step=0, adder_init_mode=`DEFAULT, adder outputs 0; mid-sweep reset abandons the sweep with no sweep_done.

Verification
REQ-019 vt[0]=100, weight[0]=150, pot 0, LIF, start -> CFG drives `VT/100; WB writes potential[0]=50, spike_vec[0]=1; weight[0]=0.
REQ-020 potential[3]=80, weight[3]=0, vt=1000 -> decayed 70 driven; potential[3]=70, spike_vec[3]=0.
REQ-021 adder_done tied 0 -> each neuron times out after 15 WAIT cycles; timeout_err=1, tables unchanged, sweep_done still pulses once.
REQ-022 start pulsed again mid-sweep -> ignored, single sweep_done; w_wr to current idx in WB cycle -> new weight retained.
REQ-023 rst_n low during WAIT of neuron 5 -> immediate IDLE, busy=0, all potentials 0, no sweep_done.

Source files
------------

// File: rtl/neuron_scheduler.sv
// Time-shares one external potential adder across NUM_NEURONS neurons. Each sweep loads the
// threshold, fires the adder with weight and leak-decayed potential, then writes results back.
module neuron_scheduler #(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             model_sel,
  input  logic                   w_wr,
  input  logic [2:0]             w_addr,
  input  logic [31:0]            w_data,
  input  logic                   vt_wr,
  input  logic [2:0]             vt_addr,
  input  logic [31:0]            vt_data,
  input  logic [2:0]             pot_rd_addr,
  output logic [31:0]            pot_rd_data,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   timeout_err,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   adder_time_step,
  output logic [31:0]            adder_input_weight,
  output logic [31:0]            adder_decayed_potential,
  output logic [1:0]             adder_model,
  output logic [2:0]             adder_init_mode,
  output logic                   adder_load,
  input  logic [31:0]            adder_final_potential,
  input  logic                   adder_spike,
  input  logic                   adder_done
);

  // Adder init_mode encodings: normal operation and threshold load.
  localparam logic [2:0] InitDefault = 3'd0;
  localparam logic [2:0] InitVt      = 3'd1;

  localparam logic [2:0]  LastIdx = 3'(NUM_NEURONS - 1);
  localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StCfg, StSettle, StFire, StWait, StWb, StGap, StFin
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      model_q, model_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     hold_w_q, hold_w_d;
  logic [31:0]     hold_dec_q, hold_dec_d;

  logic [31:0]            weight_q [NUM_NEURONS];
  logic [31:0]            vt_q     [NUM_NEURONS];
  logic [31:0]            pot_q    [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spike_q;

  logic [31:0] cur_pot;
  logic [31:0] cur_decay;
  logic        wb_en;

  // Shift-subtract can never go below zero for an unsigned value.
  assign cur_pot   = pot_q[idx_q];
  assign cur_decay = cur_pot - (cur_pot >> DECAY_SHIFT);
  assign wb_en     = (state_q == StWb);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    model_d    = model_q;
    timeout_d  = timeout_q;
    hold_w_d   = hold_w_q;
    hold_dec_d = hold_dec_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCfg;
          idx_d     = '0;
          timeout_d = 1'b0;
          model_d   = model_sel;
        end
      end
      StCfg:    state_d = StSettle;
      StSettle: state_d = StFire;
      StFire: begin
        // Freeze adder operands so host writes during WAIT do not disturb them.
        state_d    = StWait;
        cnt_d      = '0;
        hold_w_d   = weight_q[idx_q];
        hold_dec_d = cur_decay;
      end
      StWait: begin
        if (adder_done) begin
          state_d = StWb;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: state_d = StGap;
      StGap: begin
        if (idx_q == LastIdx) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StCfg;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      model_q    <= '0;
      timeout_q  <= 1'b0;
      hold_w_q   <= '0;
      hold_dec_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      model_q    <= model_d;
      timeout_q  <= timeout_d;
      hold_w_q   <= hold_w_d;
      hold_dec_q <= hold_dec_d;
    end
  end

  // Host weight write beats the write-back clear on the same neuron.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        weight_q[i] <= '0;
        vt_q[i]     <= '0;
        pot_q[i]    <= '0;
      end
      spike_q <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_wr && (w_addr == 3'(i))) begin
          weight_q[i] <= w_data;
        end else if (wb_en && (idx_q == 3'(i))) begin
          weight_q[i] <= '0;
        end
        if (vt_wr && (vt_addr == 3'(i))) begin
          vt_q[i] <= vt_data;
        end
        if (wb_en && (idx_q == 3'(i))) begin
          pot_q[i]   <= adder_final_potential;
          spike_q[i] <= adder_spike;
        end
      end
    end
  end

  always_comb begin
    adder_time_step         = 1'b0;
    adder_input_weight      = '0;
    adder_decayed_potential = '0;
    adder_init_mode         = InitDefault;
    unique case (state_q)
      StCfg: begin
        adder_init_mode    = InitVt;
        adder_input_weight = vt_q[idx_q];
      end
      StFire: begin
        adder_time_step         = 1'b1;
        adder_input_weight      = weight_q[idx_q];
        adder_decayed_potential = cur_decay;
      end
      StWait, StWb: begin
        adder_time_step         = 1'b1;
        adder_input_weight      = hold_w_q;
        adder_decayed_potential = hold_dec_q;
      end
      default: ;
    endcase
  end

  assign pot_rd_data = (32'(pot_rd_addr) < NUM_NEURONS) ? pot_q[pot_rd_addr] : '0;
  assign busy        = (state_q != StIdle);
  assign sweep_done  = (state_q == StFin);
  assign timeout_err = timeout_q;
  assign spike_vec   = spike_q;
  assign adder_model = model_q;
  assign adder_load  = 1'b0;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler: behavioural LIF adder stub, per-neuron table model and
// per-cycle monitor, with directed sweeps covering threshold, leak, timeout and reset cases.
module tb_neuron_scheduler;
  localparam int N = 8;
  localparam logic [2:0] InitVt = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  model_sel = 2'd0;
  logic        w_wr = 1'b0;
  logic [2:0]  w_addr = 3'd0;
  logic [31:0] w_data = 32'd0;
  logic        vt_wr = 1'b0;
  logic [2:0]  vt_addr = 3'd0;
  logic [31:0] vt_data = 32'd0;
  logic [2:0]  pot_rd_addr = 3'd0;
  logic [31:0] pot_rd_data;
  logic        busy, sweep_done, timeout_err;
  logic [N-1:0] spike_vec;
  logic        adder_time_step;
  logic [31:0] adder_input_weight, adder_decayed_potential;
  logic [1:0]  adder_model;
  logic [2:0]  adder_init_mode;
  logic        adder_load;
  logic [31:0] adder_final_potential;
  logic        adder_spike, adder_done;

  always #5 clk = ~clk;

  neuron_scheduler #(.NUM_NEURONS(8), .DECAY_SHIFT(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .model_sel(model_sel),
    .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
    .vt_wr(vt_wr), .vt_addr(vt_addr), .vt_data(vt_data),
    .pot_rd_addr(pot_rd_addr), .pot_rd_data(pot_rd_data),
    .busy(busy), .sweep_done(sweep_done), .timeout_err(timeout_err), .spike_vec(spike_vec),
    .adder_time_step(adder_time_step), .adder_input_weight(adder_input_weight),
    .adder_decayed_potential(adder_decayed_potential), .adder_model(adder_model),
    .adder_init_mode(adder_init_mode), .adder_load(adder_load),
    .adder_final_potential(adder_final_potential), .adder_spike(adder_spike),
    .adder_done(adder_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // LIF adder stub: latches threshold on VT load, result = decayed + weight, reset by subtraction.
  int          adder_lat = 1;
  bit          adder_en = 1'b1;
  int          st_cnt;
  logic [31:0] st_vt, st_res, st_sum;
  logic        st_spk, ts_d;

  assign st_sum = adder_decayed_potential + adder_input_weight;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vt  <= '0;
      st_res <= '0;
      st_spk <= 1'b0;
      st_cnt <= 0;
      ts_d   <= 1'b0;
    end else begin
      ts_d <= adder_time_step;
      if (adder_init_mode == InitVt) st_vt <= adder_input_weight;
      if (adder_time_step && !ts_d) begin
        st_spk <= (st_sum >= st_vt);
        st_res <= (st_sum >= st_vt) ? st_sum - st_vt : st_sum;
        st_cnt <= adder_lat;
      end else if (st_cnt > 0) begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  assign adder_done            = adder_en && (st_cnt == 1);
  assign adder_final_potential = st_res;
  assign adder_spike           = st_spk;

  // Model of the host-visible tables, updated once per completed sweep.
  logic [31:0]  m_w [N], m_vt [N], m_pot [N];
  logic [N-1:0] m_spike;
  logic         m_to;
  logic [1:0]   m_model;
  logic [31:0]  cap_vt [N], cap_w [N], cap_dec [N];

  // Per-cycle monitor of adder-facing outputs against the model.
  initial begin
    int  cfg_cnt;
    int  fire_cnt;
    logic mon_ts_d;
    cfg_cnt = 0;
    fire_cnt = 0;
    mon_ts_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cfg_cnt = 0;
        fire_cnt = 0;
        mon_ts_d = 1'b0;
      end else begin
        check("adder_load", 32'(adder_load), 0);
        if (adder_init_mode == InitVt) begin
          if (cfg_cnt < N) begin
            check($sformatf("cfg_vt[%0d]", cfg_cnt), adder_input_weight, m_vt[cfg_cnt]);
            cap_vt[cfg_cnt] = adder_input_weight;
          end
          cfg_cnt++;
        end else begin
          check("init_mode_default", 32'(adder_init_mode), 0);
        end
        if (adder_time_step) begin
          check("busy_with_ts", 32'(busy), 1);
          if (!mon_ts_d && fire_cnt < N) begin
            check($sformatf("fire_w[%0d]", fire_cnt), adder_input_weight, m_w[fire_cnt]);
            check($sformatf("fire_dec[%0d]", fire_cnt), adder_decayed_potential,
                  m_pot[fire_cnt] - (m_pot[fire_cnt] >> 3));
            check("fire_model", 32'(adder_model), 32'(m_model));
            cap_w[fire_cnt]   = adder_input_weight;
            cap_dec[fire_cnt] = adder_decayed_potential;
            fire_cnt++;
          end
        end
        if (sweep_done) begin
          cfg_cnt = 0;
          fire_cnt = 0;
        end
        mon_ts_d = adder_time_step;
      end
    end
  end

  task automatic wr_w(input int a, input logic [31:0] d);
    @(negedge clk);
    w_wr = 1'b1; w_addr = 3'(a); w_data = d;
    @(negedge clk);
    w_wr = 1'b0;
    m_w[a] = d;
  endtask

  task automatic wr_vt(input int a, input logic [31:0] d);
    @(negedge clk);
    vt_wr = 1'b1; vt_addr = 3'(a); vt_data = d;
    @(negedge clk);
    vt_wr = 1'b0;
    m_vt[a] = d;
  endtask

  task automatic check_tables(input string tag);
    for (int i = 0; i < N; i++) begin
      pot_rd_addr = 3'(i);
      #1;
      check($sformatf("%s_pot[%0d]", tag, i), pot_rd_data, m_pot[i]);
    end
    check({tag, "_spike_vec"}, 32'(spike_vec), 32'(m_spike));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_to));
  endtask

  task automatic read_pot(input int a, output logic [31:0] v);
    pot_rd_addr = 3'(a);
    #1;
    v = pot_rd_data;
  endtask

  // k counts negedges after the edge that accepts start; sweep_done expected at k == exp_cyc.
  task automatic run_sweep(input string tag, input logic [1:0] msel, input int lat, input bit en,
                           input int exp_cyc, input bit mid_start, input int wb_idx,
                           input logic [31:0] wb_val);
    int k, done_k, n_done, wb_k;
    logic [31:0] d, s;
    adder_lat = lat;
    adder_en  = en;
    m_model   = msel;
    wb_k      = wb_idx * (5 + lat) + 3 + lat;
    @(negedge clk);
    model_sel = msel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; done_k = -1; n_done = 0;
    while (k < 400 && (done_k < 0 || k < done_k + 4)) begin
      if (k == 0) check({tag, "_to_cleared"}, 32'(timeout_err), 0);
      if (sweep_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (mid_start) begin
        if (k == 10) begin
          start = 1'b1;
          model_sel = ~msel;
        end else if (k == 11) begin
          start = 1'b0;
        end
      end
      if (wb_idx >= 0) begin
        if (k == wb_k) begin
          w_wr = 1'b1; w_addr = 3'(wb_idx); w_data = wb_val;
        end else if (k == wb_k + 1) begin
          w_wr = 1'b0;
        end
      end
      @(negedge clk);
      k++;
    end
    if (done_k < 0) check({tag, "_sweep_done_seen"}, 0, 1);
    check({tag, "_cycles"}, 32'(done_k), 32'(exp_cyc));
    check({tag, "_done_pulses"}, 32'(n_done), 1);
    for (int i = 0; i < N; i++) begin
      if (en) begin
        d = m_pot[i] - (m_pot[i] >> 3);
        s = d + m_w[i];
        m_spike[i] = (s >= m_vt[i]);
        if (s >= m_vt[i]) s = s - m_vt[i];
        m_pot[i] = s;
        m_w[i] = '0;
      end
    end
    m_to = !en;
    if (wb_idx >= 0) m_w[wb_idx] = wb_val;
    check_tables(tag);
  endtask

  initial begin
    logic [31:0] v;
    int n_done;
    for (int i = 0; i < N; i++) begin
      m_w[i] = '0; m_vt[i] = '0; m_pot[i] = '0;
    end
    m_spike = '0; m_to = 1'b0; m_model = 2'd0;

    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    check("rst_time_step", 32'(adder_time_step), 0);
    check("rst_init_mode", 32'(adder_init_mode), 0);
    check("rst_input_weight", adder_input_weight, 0);
    check("rst_decayed", adder_decayed_potential, 0);
    check("rst_model", 32'(adder_model), 0);
    check_tables("rst");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep 1: neuron 0 crosses threshold, neuron 3 charges to 80.
    for (int i = 0; i < N; i++) begin
      wr_vt(i, 60);
      wr_w(i, 40 * i);
    end
    wr_vt(0, 100); wr_w(0, 150);
    wr_vt(3, 1000); wr_w(3, 80);
    run_sweep("s1", 2'd0, 1, 1'b1, 48, 1'b0, -1, 0);
    check("s1_cfg_vt0_lit", cap_vt[0], 100);
    read_pot(0, v); check("s1_pot0_lit", v, 50);
    read_pot(3, v); check("s1_pot3_lit", v, 80);
    check("s1_spike0_lit", 32'(spike_vec[0]), 1);

    // Sweep 2: leak only on neuron 3, wrapping sum on neuron 6.
    wr_vt(6, 32'hFFFF_FFFF);
    wr_w(6, 32'hFFFF_FFF0);
    wr_w(7, 32'h1234_5678);
    run_sweep("s2", 2'd1, 3, 1'b1, 64, 1'b0, -1, 0);
    check("s2_dec3_lit", cap_dec[3], 70);
    read_pot(3, v); check("s2_pot3_lit", v, 70);
    read_pot(0, v); check("s2_pot0_lit", v, 44);
    read_pot(6, v); check("s2_pot6_wrap_lit", v, 142);
    check("s2_spike3_lit", 32'(spike_vec[3]), 0);

    // Sweep 3: adder never answers, every neuron times out.
    wr_w(1, 77);
    run_sweep("s3", 2'd0, 1, 1'b0, 152, 1'b0, -1, 0);
    check("s3_timeout_lit", 32'(timeout_err), 1);

    // Sweep 4: stray start mid-sweep, host weight write in neuron 2's WB cycle.
    run_sweep("s4", 2'd2, 2, 1'b1, 56, 1'b1, 2, 32'h0000_ABCD);
    check("s4_w1_lit", cap_w[1], 77);

    run_sweep("s5", 2'd0, 1, 1'b1, 48, 1'b0, -1, 0);
    check("s5_w2_kept_lit", cap_w[2], 32'h0000_ABCD);

    // Reset asserted during neuron 5's first WAIT cycle.
    adder_lat = 3; adder_en = 1'b1; m_model = 2'd0;
    @(negedge clk);
    model_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 43; k++) @(negedge clk);
    check("mr_in_wait_ts", 32'(adder_time_step), 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      m_w[i] = '0; m_vt[i] = '0; m_pot[i] = '0;
    end
    m_spike = '0; m_to = 1'b0;
    check("mr_busy", 32'(busy), 0);
    check("mr_time_step", 32'(adder_time_step), 0);
    check_tables("mr");
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sweep_done) n_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (sweep_done) n_done++;
    end
    check("mr_no_sweep_done", 32'(n_done), 0);
    check("mr_idle_busy", 32'(busy), 0);

    // Sweep 7: zero thresholds after reset, every neuron spikes.
    run_sweep("s7", 2'd3, 1, 1'b1, 48, 1'b0, -1, 0);
    check("s7_spikes_lit", 32'(spike_vec), 32'h0000_00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
